// File: rtl/whack_pkg.sv
// Shared constants for the whack-a-mole game memory path: game_mem geometry,
// arbiter FSM state encoding, latched transaction record and address map.
package whack_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  // game_mem address map
  localparam logic [ADDR_W-1:0] SCORE_ADDR    = 5'd0;
  localparam logic [ADDR_W-1:0] TOPSCORE_ADDR = 5'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  // One granted access, frozen at grant time
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_txn_t;

  // Index width for n items, never narrower than one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/game_mem_arbiter_if.sv
// Requester + game_mem bus for game_mem_arbiter.
// master: requesters and the RAM (drive req/we/addr/wdata and mem_q).
// slave : the arbiter (drives ack/rdata/busy and the RAM port).
interface game_mem_arbiter_if
  import whack_pkg::*;
#(
  parameter int N_REQ = 3
) ();

  logic [N_REQ-1:0]             req;
  logic [N_REQ-1:0]             we;
  logic [N_REQ-1:0][ADDR_W-1:0] addr;
  logic [N_REQ-1:0][DATA_W-1:0] wdata;
  logic [N_REQ-1:0]             ack;
  logic [DATA_W-1:0]            rdata;
  logic                         busy;
  logic [ADDR_W-1:0]            mem_address;
  logic [DATA_W-1:0]            mem_data;
  logic                         mem_wren;
  logic [DATA_W-1:0]            mem_q;

  modport master (
    output req, we, addr, wdata, mem_q,
    input  ack, rdata, busy, mem_address, mem_data, mem_wren
  );

  modport slave (
    input  req, we, addr, wdata, mem_q,
    output ack, rdata, busy, mem_address, mem_data, mem_wren
  );

endinterface

// File: rtl/game_mem_arbiter_rr_arbiter.sv
// Combinational grant selector for game_mem_arbiter.
// Default: round-robin, search starts at ptr (= last winner + 1).
// GAME_MEM_ARB_FIXED_PRIO_EN: fixed priority, lowest index wins, no ptr port.
module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
`ifndef GAME_MEM_ARB_FIXED_PRIO_EN
  input  logic [IDX_W-1:0] ptr,
`endif
  output logic             any,
  output logic [IDX_W-1:0] gnt_idx
);

`ifdef GAME_MEM_ARB_FIXED_PRIO_EN
  // Scan from the top down so the lowest requesting index is the last writer
  always_comb begin
    any     = 1'b0;
    gnt_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        any     = 1'b1;
        gnt_idx = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] idx;

  // Scan offsets from farthest to nearest so the first hit after ptr wins
  always_comb begin
    any     = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      idx = IDX_W'((int'(ptr) + off) % N_REQ);
      if (req[idx]) begin
        any     = 1'b1;
        gnt_idx = idx;
      end
    end
  end
`endif

endmodule

// File: rtl/game_mem_arbiter.sv
// game_mem_arbiter: serializes N_REQ requesters onto the single-port game_mem.
// IDLE -> ISSUE -> (WAIT x RD_LATENCY, reads) -> DONE -> IDLE, one access at a
// time, all RAM-port and requester outputs registered.
// Build option GAME_MEM_ARB_FIXED_PRIO_EN: fixed priority (req[0] highest),
// round-robin pointer removed.
module game_mem_arbiter
  import whack_pkg::*;
#(
  parameter int N_REQ      = 3,
  parameter int RD_LATENCY = 1
) (
  input logic               clk,
  input logic               resetn,
  game_mem_arbiter_if.slave bus
);

  localparam int IDX_W = idx_w(N_REQ);
  localparam int CNT_W = idx_w(RD_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LATENCY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  winner_q, winner_d;
  mem_txn_t          txn_q, txn_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              mem_wren_q, mem_wren_d;

  logic              gnt_any;
  logic [IDX_W-1:0]  gnt_idx;

`ifndef GAME_MEM_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]  ptr_q, ptr_d;
`endif

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req     (bus.req),
`ifndef GAME_MEM_ARB_FIXED_PRIO_EN
    .ptr     (ptr_q),
`endif
    .any     (gnt_any),
    .gnt_idx (gnt_idx)
  );

  // Next-state and next-output decode for the whole transaction sequence
  always_comb begin
    state_d    = state_q;
    winner_d   = winner_q;
    txn_d      = txn_q;
    cnt_d      = cnt_q;
    ack_d      = '0;
    rdata_d    = rdata_q;
    busy_d     = busy_q;
    mem_wren_d = 1'b0;
`ifndef GAME_MEM_ARB_FIXED_PRIO_EN
    ptr_d      = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          // Freeze the winner's request; later input changes are ignored
          winner_d   = gnt_idx;
          txn_d      = '{we:    bus.we[gnt_idx],
                         addr:  bus.addr[gnt_idx],
                         wdata: bus.wdata[gnt_idx]};
          mem_wren_d = bus.we[gnt_idx];
          busy_d     = 1'b1;
          state_d    = ISSUE;
`ifndef GAME_MEM_ARB_FIXED_PRIO_EN
          ptr_d      = (gnt_idx == IDX_LAST) ? '0 : gnt_idx + 1'b1;
`endif
        end
      end
      ISSUE: begin
        if (txn_q.we) begin
          ack_d[winner_q] = 1'b1;
          state_d         = DONE;
        end else begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          rdata_d         = bus.mem_q;
          ack_d[winner_q] = 1'b1;
          state_d         = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any in-flight access
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      winner_q   <= '0;
      txn_q      <= '0;
      cnt_q      <= '0;
      ack_q      <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      mem_wren_q <= 1'b0;
`ifndef GAME_MEM_ARB_FIXED_PRIO_EN
      ptr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      winner_q   <= winner_d;
      txn_q      <= txn_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      mem_wren_q <= mem_wren_d;
`ifndef GAME_MEM_ARB_FIXED_PRIO_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  // RAM port is driven straight from the latched transaction
  assign bus.mem_address = txn_q.addr;
  assign bus.mem_data    = txn_q.wdata;
  assign bus.mem_wren    = mem_wren_q;
  assign bus.ack         = ack_q;
  assign bus.rdata       = rdata_q;
  assign bus.busy        = busy_q;

endmodule
